// File: rtl/tick_meter_pkg.sv
// ----------------------------------------------------------------------------
// tick_meter_pkg
// Shared types and constants for the tick period meter.
//   meter_state_t    : measurement FSM state encoding
//   MIN_SYNC_STAGES  : fewest synchronizer flops allowed on the async input
//   MAX_SYNC_STAGES  : most synchronizer flops allowed on the async input
// ----------------------------------------------------------------------------
package tick_meter_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        OVF     = 2'd2
    } meter_state_t;

endpackage : tick_meter_pkg

// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous pulse train into the clk domain through a flop
// chain, then compares the synchronized level with a one-cycle-delayed copy
// to produce single-cycle rise/fall strobes.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   tick_in : asynchronous input level
//   sync    : synchronized level (last synchronizer flop)
//   rise    : one-cycle strobe on a synchronized 0->1 transition
//   fall    : one-cycle strobe on a synchronized 1->0 transition
// ----------------------------------------------------------------------------
module sync_edge_detect
    import tick_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    // Reject illegal chain lengths at elaboration time.
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("sync_edge_detect: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchronizer chain plus the delay flop used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edges are decoded combinationally so the FSM acts on them at the very
    // next edge; sync and dly can never disagree in both directions at once.
    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule : sync_edge_detect

// File: rtl/tick_period_meter.sv
// ----------------------------------------------------------------------------
// tick_period_meter
// Measures the period (rise to rise) and high time (rise to fall) of an
// asynchronous pulse train in clk cycles, publishes each new period with a
// one-cycle strobe, flags saturation of the interval counter, and reports
// lock when two consecutive published periods match.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   tick_in      : measured pulse train, asynchronous to clk
//   en           : measurement enable; low parks the meter, results hold
//   clr          : synchronous clear of results, flags and state
//   period       : clk cycles between the last two synchronized rises
//   high_time    : clk cycles high in the last complete pulse
//   period_valid : one-cycle strobe when period updates
//   overflow     : sticky, counter saturated before an edge arrived
//   locked       : last two published periods were equal
// ----------------------------------------------------------------------------
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned N           = 28,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_in,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] period,
    output logic [N-1:0] high_time,
    output logic         period_valid,
    output logic         overflow,
    output logic         locked
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic sync_unused;
    logic rise;
    logic fall;

    meter_state_t state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_q, period_d;
    logic [N-1:0] high_q, high_d;
    logic         pv_q, pv_d;
    logic         ovf_q, ovf_d;
    logic         locked_q, locked_d;
    // Set once period_q holds a value published in the current run, so the
    // first publish after IDLE/OVF never reports lock.
    logic         have_prev_q, have_prev_d;

    // Input synchronization and edge detection.
    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .sync    (sync_unused),
        .rise    (rise),
        .fall    (fall)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; clr and en override edge activity.
    always_comb begin
        state_d = state_q;
        if (clr || !en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (!rise && (cnt_q == CNT_MAX)) begin
                        state_d = OVF;
                    end
                end
                OVF: begin
                    if (rise) begin
                        state_d = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM output logic: next values for the counter and result registers.
    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        pv_d        = 1'b0;
        ovf_d       = ovf_q;
        locked_d    = locked_q;
        have_prev_d = have_prev_q;

        if (clr) begin
            cnt_d       = '0;
            period_d    = '0;
            high_d      = '0;
            ovf_d       = 1'b0;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
        end else if (!en) begin
            cnt_d       = '0;
            have_prev_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // First rise only opens the interval; nothing to publish.
                    cnt_d = rise ? CNT_ONE : '0;
                end
                MEASURE: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        pv_d        = 1'b1;
                        locked_d    = have_prev_q && (cnt_q == period_q);
                        have_prev_d = 1'b1;
                        cnt_d       = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // Saturate rather than wrap; the interval is lost.
                        ovf_d       = 1'b1;
                        locked_d    = 1'b0;
                        have_prev_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (fall) begin
                        high_d = cnt_q;
                    end
                end
                OVF: begin
                    // Restart timing on the next rise but discard that interval.
                    if (rise) begin
                        cnt_d = CNT_ONE;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // Interval counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Published results and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q    <= '0;
            high_q      <= '0;
            pv_q        <= 1'b0;
            ovf_q       <= 1'b0;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            period_q    <= period_d;
            high_q      <= high_d;
            pv_q        <= pv_d;
            ovf_q       <= ovf_d;
            locked_q    <= locked_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = pv_q;
    assign overflow     = ovf_q;
    assign locked       = locked_q;

endmodule : tick_period_meter

// File: tb/tb_tick_period_meter.sv
// ----------------------------------------------------------------------------
// tb_tick_period_meter
// Two meters (N=4/SYNC=2 and N=8/SYNC=3) share one stimulus stream. A
// timestamp-based model predicts every output each cycle; directed sequences
// add hand-computed expectations on instance A.
// ----------------------------------------------------------------------------
module tb_tick_period_meter;

    localparam int N_A  = 4;
    localparam int SS_A = 2;
    localparam int N_B  = 8;
    localparam int SS_B = 3;

    localparam int M_IDLE = 0;
    localparam int M_MEAS = 1;
    localparam int M_OVF  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_in = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    logic [N_A-1:0] period_a, high_a;
    logic           pv_a, ovf_a, locked_a;
    logic [N_B-1:0] period_b, high_b;
    logic           pv_b, ovf_b, locked_b;

    int checks   = 0;
    int failures = 0;
    int pv_q[$];

    always #5 clk = ~clk;

    tick_period_meter #(.N(N_A), .SYNC_STAGES(SS_A)) dut_a (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .clr(clr),
        .period(period_a), .high_time(high_a), .period_valid(pv_a),
        .overflow(ovf_a), .locked(locked_a)
    );

    tick_period_meter #(.N(N_B), .SYNC_STAGES(SS_B)) dut_b (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .clr(clr),
        .period(period_b), .high_time(high_b), .period_valid(pv_b),
        .overflow(ovf_b), .locked(locked_b)
    );

    // Model state: edge timestamps instead of a running counter.
    typedef struct {
        int mode;
        int last;
        int period;
        int high;
        bit pv;
        bit ovf;
        bit locked;
        bit have_prev;
    } mdl_t;

    mdl_t ma, mb;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mreset(inout mdl_t m);
        m.mode = M_IDLE; m.last = 0; m.period = 0; m.high = 0;
        m.pv = 0; m.ovf = 0; m.locked = 0; m.have_prev = 0;
    endfunction

    // One clock edge of the model. r/f: synchronized rise/fall acting at edge e.
    function automatic void mstep(inout mdl_t m, input bit r, input bit f,
                                  input bit e_n, input bit c, input int e, input int maxc);
        int el;
        el = e - m.last;
        m.pv = 0;
        if (c) begin
            m.mode = M_IDLE; m.period = 0; m.high = 0;
            m.ovf = 0; m.locked = 0; m.have_prev = 0;
        end else if (!e_n) begin
            m.mode = M_IDLE; m.have_prev = 0;
        end else if (m.mode == M_MEAS) begin
            if (f) m.high = el;
            if (r) begin
                m.locked = m.have_prev && (el == m.period);
                m.period = el;
                m.pv = 1;
                m.have_prev = 1;
                m.last = e;
            end else if (el == maxc) begin
                m.mode = M_OVF; m.ovf = 1; m.locked = 0; m.have_prev = 0;
            end
        end else if (r) begin
            m.mode = M_MEAS;
            m.last = e;
        end
    endfunction

    // Model process: a rise sampled first at edge k acts at edge k+SYNC_STAGES.
    initial begin
        logic [7:0] hist;
        int edge_n;
        hist = '0;
        edge_n = 0;
        mreset(ma);
        mreset(mb);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist = '0;
                mreset(ma);
                mreset(mb);
            end else begin
                edge_n++;
                hist = {hist[6:0], tick_in};
                mstep(ma, hist[SS_A] & ~hist[SS_A+1], ~hist[SS_A] & hist[SS_A+1],
                      en, clr, edge_n, (1 << N_A) - 1);
                mstep(mb, hist[SS_B] & ~hist[SS_B+1], ~hist[SS_B] & hist[SS_B+1],
                      en, clr, edge_n, (1 << N_B) - 1);
            end
        end
    end

    // Compare process: every cycle outside reset.
    initial begin
        bit prev_pv_a;
        prev_pv_a = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("a_period",    int'(period_a), ma.period);
                chk("a_high_time", int'(high_a),   ma.high);
                chk("a_valid",     int'(pv_a),     int'(ma.pv));
                chk("a_overflow",  int'(ovf_a),    int'(ma.ovf));
                chk("a_locked",    int'(locked_a), int'(ma.locked));
                chk("b_period",    int'(period_b), mb.period);
                chk("b_high_time", int'(high_b),   mb.high);
                chk("b_valid",     int'(pv_b),     int'(mb.pv));
                chk("b_overflow",  int'(ovf_b),    int'(mb.ovf));
                chk("b_locked",    int'(locked_b), int'(mb.locked));
                chk("a_valid_back_to_back", int'(pv_a & prev_pv_a), 0);
                prev_pv_a = pv_a;
            end else begin
                prev_pv_a = 0;
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+2.
    task automatic cyc(input logic t, input logic e, input logic c);
        tick_in = t;
        en = e;
        clr = c;
        @(negedge clk);
        if (!rst && pv_a) pv_q.push_back(int'(period_a));
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int hi, input int total);
        for (int i = 0; i < total; i++) cyc(i < hi, 1'b1, 1'b0);
    endtask

    task automatic clear_meter();
        cyc(1'b0, 1'b1, 1'b1);
        pv_q.delete();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_period", int'(period_a), 0);
        chk("reset_flags", int'({pv_a, ovf_a, locked_a}), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        settle(4);

        // 1-cycle pulses every 10 clk
        clear_meter();
        pulse(1, 10); pulse(1, 10); pulse(1, 10);
        settle(2);
        chk("p10_publishes", pv_q.size(), 2);
        if (pv_q.size() == 2) begin
            chk("p10_first", pv_q[0], 10);
            chk("p10_second", pv_q[1], 10);
        end
        chk("p10_period", int'(period_a), 10);
        chk("p10_high", int'(high_a), 1);
        chk("p10_locked", int'(locked_a), 1);
        chk("p10_model_locked", int'(ma.locked), 1);

        // spacing 10 then 12, 3 cycles high
        clear_meter();
        pulse(3, 10); pulse(3, 12); pulse(3, 6);
        settle(2);
        chk("p10_12_publishes", pv_q.size(), 2);
        if (pv_q.size() == 2) begin
            chk("p10_12_first", pv_q[0], 10);
            chk("p10_12_second", pv_q[1], 12);
        end
        chk("p10_12_high", int'(high_a), 3);
        chk("p10_12_locked", int'(locked_a), 0);
        chk("p10_12_model_period", ma.period, 12);

        // saturation on the 4-bit instance
        clear_meter();
        pulse(1, 21);
        chk("ovf_flag", int'(ovf_a), 1);
        chk("ovf_no_publish", pv_q.size(), 0);
        pulse(1, 6); pulse(1, 6);
        settle(3);
        chk("ovf_publishes", pv_q.size(), 1);
        if (pv_q.size() == 1) chk("ovf_then_period", pv_q[0], 6);
        chk("ovf_sticky", int'(ovf_a), 1);
        chk("ovf_locked", int'(locked_a), 0);
        chk("ovf_model_period", ma.period, 6);

        // clr in the same cycle the rise is acted on
        pv_q.delete();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_period", int'(period_a), 0);
        chk("clr_overflow", int'(ovf_a), 0);
        chk("clr_locked", int'(locked_a), 0);
        chk("clr_valid", int'(pv_a), 0);
        settle(3);
        pulse(1, 5);
        settle(2);
        chk("clr_idle_no_publish", pv_q.size(), 0);

        // enable dropped mid-period
        clear_meter();
        pulse(1, 10); pulse(1, 5);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        settle(2);
        chk("en_hold_period", int'(period_a), 10);
        chk("en_publishes_before", pv_q.size(), 1);
        pulse(1, 7);
        chk("en_first_rise_no_publish", pv_q.size(), 1);
        chk("en_period_still", int'(period_a), 10);
        pulse(1, 4);
        settle(2);
        chk("en_publishes_after", pv_q.size(), 2);
        if (pv_q.size() == 2) chk("en_new_period", pv_q[1], 7);
        chk("en_locked", int'(locked_a), 0);

        // asynchronous reset between edges mid-measurement
        clear_meter();
        pulse(1, 8); pulse(1, 8);
        settle(2);
        chk("rst_pre_period", int'(period_a), 8);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_period_a", int'(period_a), 0);
        chk("rst_async_high_a", int'(high_a), 0);
        chk("rst_async_flags_a", int'({pv_a, ovf_a, locked_a}), 0);
        chk("rst_async_period_b", int'(period_b), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        pv_q.delete();
        pulse(1, 8);
        chk("rst_first_rise_no_publish", pv_q.size(), 0);
        pulse(1, 5);
        settle(2);
        chk("rst_publishes", pv_q.size(), 1);
        if (pv_q.size() == 1) chk("rst_period", pv_q[0], 8);

        // randomized pulse trains with sporadic enable drops and clears
        for (int s = 0; s < 450; s++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 6);
            lo = ($urandom_range(0, 29) == 0) ? 300 : $urandom_range(1, 14);
            for (int i = 0; i < hi + lo; i++)
                cyc(i < hi, $urandom_range(0, 99) >= 2, $urandom_range(0, 299) == 0);
        end
        settle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tick_period_meter
